game_collision_detector: RTL and testbench

- Upstream of the game master FSM; produces its `collision` and `collision_bullet` inputs, plus a per-target hit mask.
- Watches per-pixel sprite enable masks during the raster scan and counts overlapping pixels per frame.
- At each frame boundary, publishes registered collision flags that stay stable for the whole next frame.
- The FSM samples stable levels, so raster-position glitches never reach it.

---
 rtl/game_collision_detector.sv | 141 ++++++++++++++
 tb/tb_game_collision_detector.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_collision_detector.sv
// Per-frame sprite overlap counter feeding registered collision flags to the game FSM.
// Optional sticky/clear behaviour: define GAME_COLLISION_STICKY_EN.
module game_collision_detector #(
  parameter int MIN_OVERLAP_PIXELS = 4,
  parameter bit VSYNC_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       vsync,
  input  logic       display_on,
  input  logic       target_1_rgb_en,
  input  logic       target_2_rgb_en,
  input  logic       target_3_rgb_en,
  input  logic       spaceship_rgb_en,
  input  logic       bullet_rgb_en,
  input  logic       clear,
  output logic       collision,
  output logic       collision_bullet,
  output logic [2:0] hit_mask,
  output logic       frame_done
);

  localparam int CW = $clog2(MIN_OVERLAP_PIXELS + 1);
  localparam logic [CW-1:0] CMAX = CW'(MIN_OVERLAP_PIXELS);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACCUM,
    REPORT
  } state_t;

  state_t state, state_nxt;

  logic vs_act, vs_q, boundary;
  logic cnt_clr, cnt_en, load;
  logic [2:0] tgt;
  logic [5:0] ovl, hit;
  logic [CW-1:0] cnt [6];

  assign vs_act   = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
  assign boundary = vs_act & ~vs_q;

  assign tgt = {target_3_rgb_en, target_2_rgb_en, target_1_rgb_en};
  // [2:0] spaceship vs targets, [5:3] bullet vs targets
  assign ovl = {{3{display_on & bullet_rgb_en}} & tgt,
                {3{display_on & spaceship_rgb_en}} & tgt};

  always_comb begin
    hit = '0;
    for (int i = 0; i < 6; i++)
      hit[i] = (cnt[i] == CMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q  <= 1'b0;
      state <= WAIT_FRAME;
    end else begin
      vs_q  <= vs_act;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    load      = 1'b0;
    case (state)
      WAIT_FRAME: begin
        cnt_clr = 1'b1;
        if (boundary) state_nxt = ACCUM;
      end
      ACCUM: begin
        cnt_clr = ~enable;
        cnt_en  = enable;
        if (boundary) state_nxt = REPORT;
      end
      REPORT: begin
        cnt_clr   = 1'b1;
        load      = 1'b1;
        state_nxt = ACCUM;
      end
      default: state_nxt = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (cnt_clr)
          cnt[i] <= '0;
        else if (cnt_en && ovl[i] && cnt[i] != CMAX)
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  logic [2:0] mask_new, mask_hold;
  logic       coll_new, coll_hold;

`ifdef GAME_COLLISION_STICKY_EN
  // clear drops only the old values; a coincident report still lands
  assign mask_hold = hit_mask & {3{~clear}};
  assign coll_hold = collision & ~clear;
  assign mask_new  = hit[5:3] | mask_hold;
  assign coll_new  = (|hit[2:0]) | coll_hold;
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign mask_hold = hit_mask;
  assign coll_hold = collision;
  assign mask_new  = hit[5:3];
  assign coll_new  = |hit[2:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision        <= 1'b0;
      collision_bullet <= 1'b0;
      hit_mask         <= '0;
      frame_done       <= 1'b0;
    end else begin
      frame_done <= load;
      if (load) begin
        collision        <= enable & coll_new;
        hit_mask         <= mask_new & {3{enable}};
        collision_bullet <= enable & (|mask_new);
      end else begin
        collision        <= coll_hold;
        hit_mask         <= mask_hold;
        collision_bullet <= |mask_hold;
      end
    end
  end

endmodule

// File: tb/tb_game_collision_detector.sv
// Scoreboard bench for game_collision_detector: frame stimulus pushes
// expected reports, a negedge monitor pops and compares them.
module tb_game_collision_detector;

  localparam int MIN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic vsync = 1'b1;
  logic display_on = 1'b0;
  logic t1 = 1'b0, t2 = 1'b0, t3 = 1'b0;
  logic ship = 1'b0, bullet = 1'b0;
  logic clear = 1'b0;
  logic collision, collision_bullet, frame_done;
  logic [2:0] hit_mask;

  always #5 clk = ~clk;

  game_collision_detector #(
    .MIN_OVERLAP_PIXELS(MIN),
    .VSYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .vsync(vsync),
    .display_on(display_on),
    .target_1_rgb_en(t1),
    .target_2_rgb_en(t2),
    .target_3_rgb_en(t3),
    .spaceship_rgb_en(ship),
    .bullet_rgb_en(bullet),
    .clear(clear),
    .collision(collision),
    .collision_bullet(collision_bullet),
    .hit_mask(hit_mask),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic       coll;
    logic       cb;
    logic [2:0] mask;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t pe;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mcnt[6];
  bit armed = 1'b0;
  logic cur_coll = 1'b0, cur_cb = 1'b0;
  logic [2:0] cur_mask = '0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) begin
        if (sb.size() == 0) begin
          check_eq("fd_spurious", frame_done, 0);
        end else begin
          pe = sb.pop_front();
          check_eq("fd_latency", cyc, pe.due);
          check_eq("collision", collision, pe.coll);
          check_eq("collision_bullet", collision_bullet, pe.cb);
          check_eq("hit_mask", hit_mask, pe.mask);
          cur_coll = pe.coll;
          cur_cb   = pe.cb;
          cur_mask = pe.mask;
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        check_eq("fd_missing", frame_done, 1);
        void'(sb.pop_front());
      end
      check_eq("stable", {collision, collision_bullet, hit_mask},
               {cur_coll, cur_cb, cur_mask});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(bit don, bit s, bit b, logic [2:0] t, int n);
    for (int k = 0; k < n; k++) begin
      display_on = don;
      ship = s;
      bullet = b;
      {t3, t2, t1} = t;
      @(posedge clk);
      if (armed) begin
        for (int i = 0; i < 3; i++) begin
          if (!enable) begin
            mcnt[i] = 0;
            mcnt[i+3] = 0;
          end else begin
            if (don && s && t[i] && mcnt[i] < MIN) mcnt[i]++;
            if (don && b && t[i] && mcnt[i+3] < MIN) mcnt[i+3]++;
          end
        end
      end
      #1;
    end
    display_on = 1'b0;
    ship = 1'b0;
    bullet = 1'b0;
    {t3, t2, t1} = 3'b000;
  endtask

  task automatic vpulse(int len);
    exp_t e;
    logic [2:0] m;
    logic c;
    vsync = 1'b0;
    if (armed) begin
      m = '0;
      c = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (mcnt[i] == MIN) c = 1'b1;
        if (mcnt[i+3] == MIN) m[i] = 1'b1;
      end
      if (!enable) begin
        m = '0;
        c = 1'b0;
      end
`ifdef GAME_COLLISION_STICKY_EN
      else begin
        m = m | cur_mask;
        c = c | cur_coll;
      end
`endif
      e.coll = c;
      e.mask = m;
      e.cb   = |m;
      e.due  = cyc + 2;
      sb.push_back(e);
    end
    armed = 1'b1;
    for (int i = 0; i < 6; i++) mcnt[i] = 0;
    repeat (len) step();
    vsync = 1'b1;
    repeat (4) step();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
`ifdef GAME_COLLISION_STICKY_EN
    cur_coll = 1'b0;
    cur_cb   = 1'b0;
    cur_mask = '0;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 6; i++) mcnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_collision", collision, 0);
    check_eq("rst_collision_bullet", collision_bullet, 0);
    check_eq("rst_hit_mask", hit_mask, 0);
    check_eq("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    repeat (2) step();

    // partial first frame: arms only
    pix(1, 1, 1, 3'b000, 20);
    vpulse(3);
    pix(1, 1, 1, 3'b000, 20);
    vpulse(3);

    // bullet vs target 2, exactly MIN pixels
    pix(1, 0, 1, 3'b010, 4);
    pix(1, 0, 0, 3'b000, 5);
    vpulse(3);

    pix(1, 0, 0, 3'b000, 10);
    vpulse(3);
`ifdef GAME_COLLISION_STICKY_EN
    pulse_clear();
    repeat (3) step();
`endif

    // MIN-1 visible overlaps plus one blanked
    pix(1, 1, 0, 3'b001, 3);
    pix(0, 1, 0, 3'b001, 1);
    vpulse(3);

    // long overlap: saturation, no wrap
    pix(1, 1, 0, 3'b001, 302);
    vpulse(3);

    // spaceship and bullet hits in one frame
    pix(1, 1, 0, 3'b100, 4);
    pix(1, 0, 1, 3'b001, 4);
    vpulse(3);

    // reset mid-frame
    pix(1, 1, 0, 3'b010, 10);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_collision", collision, 0);
    check_eq("rst_mid_hit_mask", hit_mask, 0);
    check_eq("rst_mid_collision_bullet", collision_bullet, 0);
    armed = 1'b0;
    for (int i = 0; i < 6; i++) mcnt[i] = 0;
    cur_coll = 1'b0;
    cur_cb   = 1'b0;
    cur_mask = '0;
    sb.delete();
    repeat (2) step();
    rst = 1'b0;
    pix(1, 1, 0, 3'b010, 10);
    vpulse(3);
    pix(1, 0, 1, 3'b010, 4);
    vpulse(3);

    // enable low for a whole frame, then high
    enable = 1'b0;
    pix(1, 0, 1, 3'b100, 50);
    vpulse(3);
    enable = 1'b1;
    pix(1, 0, 1, 3'b100, 50);
    vpulse(3);

    pulse_clear();
    repeat (5) step();

    check_eq("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
